// File: rtl/sinfonia_pkg.sv
// Shared types for the Simon-style game controller: FSM state codes and width helpers.
package sinfonia_pkg;

    typedef enum logic [3:0] {
        INICIAL       = 4'h0,
        PREPARA       = 4'h1,
        TOCA_NOTA     = 4'h2,
        PAUSA_NOTA    = 4'h3,
        ESPERA_JOGADA = 4'h4,
        ESPERA_SOLTAR = 4'h5,
        COMPARA       = 4'h6,
        ERRO          = 4'h7,
        FIM_RODADA    = 4'h8,
        FIM_ACERTOU   = 4'h9,
        FIM_ERROU     = 4'hA
    } estado_t;

    // Bits needed to index 'valor' items, never less than one.
    function automatic int largura(input int valor);
        return (valor <= 2) ? 1 : $clog2(valor);
    endfunction

    function automatic int maximo3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/contador_m.sv
// Up-counter with enable, synchronous clear and terminal-count flag (fim when q == limite).
// Latency: fim is registered-state derived, valid the cycle q reaches limite.
// Backpressure: none; the count holds at limite until cleared.
module contador_m #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limite,
    output logic         fim
);

    logic [W-1:0] q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (en && !fim)
            q <= q + W'(1);
    end

    assign fim = (q == limite);

endmodule

// File: rtl/unidade_controle_param.sv
// Game control unit: plays rounds from the note ROM, checks player presses, keeps lives/score.
// Latency: Moore outputs, one cycle per control step; note/pause lengths set by parameters.
// Backpressure: none; waits on button levels. TIMEOUT_JOGADA_EN adds a player response timeout.
module unidade_controle_param
    import sinfonia_pkg::*;
#(
    parameter int N_BOTOES       = 4,
    parameter int MAX_RODADAS    = 16,
    parameter int VIDAS          = 3,
    parameter int NOTA_CICLOS    = 50,
    parameter int PAUSA_CICLOS   = 25,
    parameter int TIMEOUT_CICLOS = 500,
    parameter int PW             = 8,
    localparam int AW = largura(MAX_RODADAS),
    localparam int VW = largura(VIDAS + 1),
    localparam int TW = largura(maximo3(NOTA_CICLOS, PAUSA_CICLOS, TIMEOUT_CICLOS) + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                jogar,
    input  logic                modo_treino,
    input  logic [N_BOTOES-1:0] botoes,
    input  logic [N_BOTOES-1:0] nota_memoria,
    output logic [AW-1:0]       endereco,
    output logic [N_BOTOES-1:0] nota_tocar,
    output logic                tocando,
    output logic [AW-1:0]       rodada,
    output logic [PW-1:0]       pontos,
    output logic [VW-1:0]       vidas,
    output logic                pronto,
    output logic                acertou,
    output logic                errou,
    output logic [3:0]          db_estado
);

    estado_t               estado, estado_prox;
    logic                  treino;
    logic [N_BOTOES-1:0]   jogada;
    logic                  troca;
    logic                  fim_tempo;
    logic                  estouro;
    logic [TW-1:0]         limite_tempo;
    logic                  ultimo;
    logic [PW:0]           soma;
    logic [PW-1:0]         pontos_sat;

    assign ultimo = (endereco == rodada);
    assign troca  = (estado_prox != estado);

    // Every state change reloads the timers, so each timed state starts counting from zero.
    assign limite_tempo = (estado == TOCA_NOTA) ? TW'(NOTA_CICLOS - 1) : TW'(PAUSA_CICLOS - 1);

    contador_m #(.W(TW)) u_tempo (
        .clock  (clock),
        .reset  (reset),
        .clr    (troca),
        .en     ((estado == TOCA_NOTA) || (estado == PAUSA_NOTA)),
        .limite (limite_tempo),
        .fim    (fim_tempo)
    );

`ifdef TIMEOUT_JOGADA_EN
    contador_m #(.W(TW)) u_resposta (
        .clock  (clock),
        .reset  (reset),
        .clr    (troca),
        .en     (estado == ESPERA_JOGADA),
        .limite (TW'(TIMEOUT_CICLOS - 1)),
        .fim    (estouro)
    );
`else
    assign estouro = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            estado <= INICIAL;
        else
            estado <= estado_prox;
    end

    always_comb begin
        estado_prox = estado;
        case (estado)
            INICIAL, FIM_ACERTOU, FIM_ERROU:
                if (jogar) estado_prox = PREPARA;
            PREPARA:
                estado_prox = TOCA_NOTA;
            TOCA_NOTA:
                if (fim_tempo) estado_prox = PAUSA_NOTA;
            PAUSA_NOTA:
                if (fim_tempo) estado_prox = ultimo ? ESPERA_JOGADA : TOCA_NOTA;
            ESPERA_JOGADA:
                if (|botoes)      estado_prox = ESPERA_SOLTAR;
                else if (estouro) estado_prox = ERRO;
            ESPERA_SOLTAR:
                if (botoes == '0) estado_prox = COMPARA;
            COMPARA:
                if (jogada != nota_memoria) estado_prox = ERRO;
                else if (ultimo)            estado_prox = FIM_RODADA;
                else                        estado_prox = ESPERA_JOGADA;
            ERRO:
                estado_prox = (!treino && vidas == VW'(1)) ? FIM_ERROU : TOCA_NOTA;
            FIM_RODADA:
                estado_prox = (rodada == AW'(MAX_RODADAS - 1)) ? FIM_ACERTOU : TOCA_NOTA;
            default:
                estado_prox = INICIAL;
        endcase
    end

    assign soma       = {1'b0, pontos} + (PW + 1)'(rodada) + (PW + 1)'(1);
    assign pontos_sat = soma[PW] ? '1 : soma[PW-1:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rodada   <= '0;
            endereco <= '0;
            pontos   <= '0;
            vidas    <= VW'(VIDAS);
            jogada   <= '0;
            treino   <= 1'b0;
        end else begin
            case (estado)
                INICIAL, FIM_ACERTOU, FIM_ERROU:
                    if (jogar) treino <= modo_treino;
                PREPARA: begin
                    rodada   <= '0;
                    endereco <= '0;
                    pontos   <= '0;
                    vidas    <= VW'(VIDAS);
                end
                PAUSA_NOTA:
                    if (fim_tempo) endereco <= ultimo ? '0 : endereco + AW'(1);
                ESPERA_JOGADA:
                    if (|botoes) jogada <= botoes;
                COMPARA:
                    if (jogada == nota_memoria && !ultimo) endereco <= endereco + AW'(1);
                ERRO: begin
                    if (!treino) vidas <= vidas - VW'(1);
                    endereco <= '0;
                end
                FIM_RODADA: begin
                    if (!treino) pontos <= pontos_sat;
                    if (rodada != AW'(MAX_RODADAS - 1)) begin
                        rodada   <= rodada + AW'(1);
                        endereco <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        nota_tocar = '0;
        tocando    = 1'b0;
        pronto     = 1'b0;
        acertou    = 1'b0;
        errou      = 1'b0;
        case (estado)
            TOCA_NOTA: begin
                nota_tocar = nota_memoria;
                tocando    = 1'b1;
            end
            ERRO:        errou = 1'b1;
            FIM_ACERTOU: begin
                pronto  = 1'b1;
                acertou = 1'b1;
            end
            FIM_ERROU: begin
                pronto = 1'b1;
                errou  = 1'b1;
            end
            default: ;
        endcase
    end

    assign db_estado = estado;

endmodule

// File: tb/tb_unidade_controle_param.sv
// Directed bench for unidade_controle_param with a 4-note ROM, 4 rounds and 2 lives.
module tb_unidade_controle_param;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       jogar = 1'b0;
    logic       modo_treino = 1'b0;
    logic [3:0] botoes = 4'b0000;
    logic [3:0] nota_memoria;
    logic [1:0] endereco, rodada, vidas;
    logic [3:0] nota_tocar, db_estado;
    logic       tocando, pronto, acertou, errou;
    logic [7:0] pontos;

    logic [3:0] rom [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    assign nota_memoria = rom[endereco];

    int n_total = 0;
    int n_pass  = 0;
    int exp_pontos;

    unidade_controle_param #(
        .N_BOTOES(4), .MAX_RODADAS(4), .VIDAS(2),
        .NOTA_CICLOS(3), .PAUSA_CICLOS(2), .TIMEOUT_CICLOS(10), .PW(8)
    ) dut (
        .clock(clock), .reset(reset), .jogar(jogar), .modo_treino(modo_treino),
        .botoes(botoes), .nota_memoria(nota_memoria), .endereco(endereco),
        .nota_tocar(nota_tocar), .tocando(tocando), .rodada(rodada), .pontos(pontos),
        .vidas(vidas), .pronto(pronto), .acertou(acertou), .errou(errou),
        .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        reset = 1'b1; jogar = 1'b0; botoes = 4'b0000; modo_treino = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic start_game(input logic treino);
        modo_treino = treino;
        jogar = 1'b1;
        tick();
        jogar = 1'b0;
        modo_treino = 1'b0;
        chk("prepara", db_estado, 4'h1);
        tick();
    endtask

    // Expects to be called on the first TOCA_NOTA cycle of round r.
    task automatic playback(input int r);
        chk("rodada_playback", rodada, r);
        for (int n = 0; n <= r; n++) begin
            for (int c = 0; c < 3; c++) begin
                chk("tocando", tocando, 1);
                chk("endereco_toca", endereco, n);
                chk("nota_tocar", nota_tocar, rom[n]);
                tick();
            end
            for (int c = 0; c < 2; c++) begin
                chk("pausa_estado", db_estado, 4'h3);
                chk("pausa_silencio", nota_tocar, 0);
                tick();
            end
        end
        chk("espera_jogada", db_estado, 4'h4);
        chk("endereco_espera", endereco, 0);
    endtask

    task automatic press(input logic [3:0] v);
        botoes = v;
        tick();
        botoes = 4'b0000;
        tick();
        tick();
    endtask

    task automatic play_round(input int r);
        for (int i = 0; i <= r; i++) press(rom[i]);
        chk("fim_rodada", db_estado, 4'h8);
        tick();
    endtask

    initial begin
        do_reset();
        chk("rst_estado", db_estado, 4'h0);
        chk("rst_vidas", vidas, 2);
        chk("rst_pontos", pontos, 0);
        chk("rst_pronto", pronto, 0);
        chk("rst_tocando", tocando, 0);
        chk("rst_nota", nota_tocar, 0);
        chk("rst_endereco", endereco, 0);
        chk("rst_rodada", rodada, 0);
        chk("rst_acertou", acertou, 0);
        chk("rst_errou", errou, 0);

        // Full correct game, exercising round timing on every round
        start_game(1'b0);
        exp_pontos = 0;
        for (int r = 0; r < 4; r++) begin
            playback(r);
            play_round(r);
            exp_pontos += r + 1;
            chk("pontos_rodada", pontos, exp_pontos);
        end
        chk("ganhou_estado", db_estado, 4'h9);
        chk("ganhou_pontos", pontos, 10);
        chk("ganhou_acertou", acertou, 1);
        chk("ganhou_pronto", pronto, 1);
        chk("ganhou_vidas", vidas, 2);
        chk("ganhou_rodada", rodada, 3);

        // Error path: wrong note at round 1, address 1
        start_game(1'b0);
        chk("novo_pontos", pontos, 0);
        chk("novo_vidas", vidas, 2);
        playback(0);
        play_round(0);
        playback(1);
        press(rom[0]);
        chk("erro_endereco1", endereco, 1);
        press(4'b1000);
        chk("erro_estado", db_estado, 4'h7);
        chk("erro_errou", errou, 1);
        tick();
        chk("replay_estado", db_estado, 4'h2);
        chk("replay_errou", errou, 0);
        chk("replay_vidas", vidas, 1);
        chk("replay_endereco", endereco, 0);
        chk("replay_rodada", rodada, 1);
        playback(1);
        press(4'b0010);
        chk("erro2_estado", db_estado, 4'h7);
        tick();
        chk("perdeu_estado", db_estado, 4'hA);
        chk("perdeu_vidas", vidas, 0);
        chk("perdeu_pronto", pronto, 1);
        chk("perdeu_errou", errou, 1);
        chk("perdeu_acertou", acertou, 0);
        chk("perdeu_pontos", pontos, 1);

        // Multi-button press; changing buttons while held must not recapture
        start_game(1'b0);
        playback(0);
        botoes = 4'b0011;
        tick();
        botoes = 4'b0001;
        for (int i = 0; i < 20; i++) begin
            chk("multi_soltar", db_estado, 4'h5);
            tick();
        end
        botoes = 4'b0000;
        tick();
        chk("multi_compara", db_estado, 4'h6);
        tick();
        chk("multi_erro", db_estado, 4'h7);
        tick();
        chk("multi_vidas", vidas, 1);

        // Long hold of the correct button
        playback(0);
        botoes = 4'b0001;
        tick();
        for (int i = 0; i < 20; i++) begin
            chk("hold_soltar", db_estado, 4'h5);
            tick();
        end
        botoes = 4'b0000;
        tick();
        tick();
        chk("hold_fim_rodada", db_estado, 4'h8);
        tick();
        chk("hold_pontos", pontos, 1);

        // Response timeout
        playback(1);
`ifdef TIMEOUT_JOGADA_EN
        repeat (9) tick();
        chk("timeout_ainda_espera", db_estado, 4'h4);
        tick();
        chk("timeout_erro", db_estado, 4'h7);
        chk("timeout_errou", errou, 1);
        tick();
        chk("timeout_perdeu", db_estado, 4'hA);
`else
        repeat (1000) tick();
        chk("sem_timeout_espera", db_estado, 4'h4);
`endif
        do_reset();

        // Training mode: five errors, then a full game
        start_game(1'b1);
        for (int k = 0; k < 5; k++) begin
            playback(0);
            press(4'b0010);
            chk("treino_erro", db_estado, 4'h7);
            tick();
            chk("treino_vidas", vidas, 2);
        end
        for (int r = 0; r < 4; r++) begin
            playback(r);
            play_round(r);
        end
        chk("treino_fim", db_estado, 4'h9);
        chk("treino_pontos", pontos, 0);
        chk("treino_vidas_fim", vidas, 2);

        // Asynchronous reset in the middle of a note, with one life already lost
        start_game(1'b0);
        playback(0);
        press(4'b0100);
        tick();
        chk("pre_reset_vidas", vidas, 1);
        tick();
        chk("pre_reset_tocando", tocando, 1);
        reset = 1'b1;
        #1;
        chk("async_estado", db_estado, 4'h0);
        chk("async_nota", nota_tocar, 0);
        chk("async_vidas", vidas, 2);
        chk("async_tocando", tocando, 0);
        tick();
        reset = 1'b0;
        tick();
        chk("pos_reset_estado", db_estado, 4'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/unidade_controle_param.md
Name: unidade_controle_param

Overview:
Parametrised successor of the game control unit for the Simon-style music game. It owns the round/note/lives/score counters and the buzzer and response timers internally, instead of relying on an external datapath for them. It is generic in button count, round count and lives. It adds a lives system, per-round scoring and a training mode, and sits between the note ROM, the button synchroniser and the buzzer/display drivers.

Parameters:
N_BOTOES, 4, number of buttons/notes; notes are one-hot of this width
MAX_RODADAS, 16, rounds per game (>=2); round r plays r+1 notes
VIDAS, 3, lives per game (>=1)
NOTA_CICLOS, 50, cycles a note sounds
PAUSA_CICLOS, 25, silent cycles between notes
TIMEOUT_CICLOS, 500, player response timeout (used only with the optional feature)
PW, 8, score width
Derived widths: AW = clog2(MAX_RODADAS), VW = clog2(VIDAS+1), TW = clog2(max of the three cycle parameters + 1)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
jogar  in  1  start pulse; honoured only in INICIAL, FIM_ACERTOU and FIM_ERROU
modo_treino  in  1  sampled when jogar is accepted; 1 = training mode
botoes  in  N_BOTOES  synchronised button levels
nota_memoria  in  N_BOTOES  expected note at endereco (combinational ROM read)
endereco  out  AW  note index into the ROM
nota_tocar  out  N_BOTOES  note to the buzzer; 0 when silent
tocando  out  1  high while in TOCA_NOTA
rodada  out  AW  current round, 0-based
pontos  out  PW  accumulated score
vidas  out  VW  lives remaining
pronto  out  1  game over (win or lose)
acertou  out  1  high in FIM_ACERTOU
errou  out  1  high in ERRO and FIM_ERROU
db_estado  out  4  state code

Behaviour:
- Reset (async, any state): state INICIAL; all outputs 0 except vidas = VIDAS; all timers 0.
- Outputs are Moore (from state and registers only). db_estado codes: INICIAL 0, PREPARA 1, TOCA_NOTA 2, PAUSA_NOTA 3, ESPERA_JOGADA 4, ESPERA_SOLTAR 5, COMPARA 6, ERRO 7, FIM_RODADA 8, FIM_ACERTOU 9, FIM_ERROU A.
- INICIAL: jogar -> PREPARA; modo_treino is latched in the same cycle.
- PREPARA (1 cycle): clear rodada, endereco, pontos and timers; vidas = VIDAS. Next state TOCA_NOTA.
- TOCA_NOTA: nota_tocar = nota_memoria, tocando = 1, for exactly NOTA_CICLOS cycles -> PAUSA_NOTA.
- PAUSA_NOTA: exactly PAUSA_CICLOS cycles. At the end:
  - if endereco == rodada: endereco = 0 -> ESPERA_JOGADA
  - otherwise: endereco += 1 -> TOCA_NOTA
- ESPERA_JOGADA: first cycle with botoes != 0 -> capture botoes into the play register -> ESPERA_SOLTAR.
- ESPERA_SOLTAR: stays while botoes != 0. The captured value is not updated. botoes == 0 -> COMPARA.
- COMPARA (1 cycle), exact equality of the play register with nota_memoria; a multi-button press is therefore a mismatch:
  - mismatch -> ERRO
  - match and endereco == rodada -> FIM_RODADA
  - otherwise endereco += 1 -> ESPERA_JOGADA
- ERRO (1 cycle):
  - normal mode: vidas -= 1; if vidas was 1 -> FIM_ERROU
  - else (normal with lives left, or training): endereco = 0 -> TOCA_NOTA (the same round replays)
  - training mode never decrements vidas.
- FIM_RODADA (1 cycle):
  - normal mode: pontos += rodada+1, saturating at 2^PW-1; training mode leaves pontos at 0.
  - if rodada == MAX_RODADAS-1 -> FIM_ACERTOU
  - otherwise: rodada += 1, endereco = 0 -> TOCA_NOTA
- FIM_ACERTOU and FIM_ERROU: pronto = 1; pontos, vidas and rodada are held. jogar -> PREPARA.
- jogar is ignored in all other states.
- Timers reload on every state entry; no timer runs in states that do not use it.

Optional Feature:
TIMEOUT_JOGADA_EN:
- Defined: a response timer runs in ESPERA_JOGADA and is cleared on each entry to that state. Reaching TIMEOUT_CICLOS cycles without a press -> ERRO, handled identically to a wrong note.
- Not defined: no response timer exists and ESPERA_JOGADA waits indefinitely; the TIMEOUT_CICLOS parameter is unused.

Decomposition:
- Package sinfonia_pkg holds the state enumeration and db_estado codes, plus a clog2-based width helper.
- One sub-module, contador_m: a parametrised up-counter with enable, synchronous clear and terminal-count flag. It is used for the note/pause timer and the timeout timer.
- The rodada, endereco, vidas and pontos registers stay inline.

Test Plan:
Common bench parameters: N_BOTOES=4, MAX_RODADAS=4, VIDAS=2, NOTA_CICLOS=3, PAUSA_CICLOS=2, TIMEOUT_CICLOS=10.
- Round timing: jogar, then observe round 2 -> three notes, each 3 cycles tocando=1 followed by 2 silent cycles; endereco steps 0,1,2; then db_estado=4.
- Full correct game -> pontos=10 (1+2+3+4), acertou=1, pronto=1, db_estado=9, vidas=2.
- Error path: wrong note at round 1, endereco 1 -> errou for 1 cycle, vidas=1, round 1 replays from endereco 0. A second wrong note -> db_estado=A, vidas=0, pronto=1.
- Multi-button press: botoes=0011 while nota_memoria=0001 -> ERRO. Separately, holding a button for 20 cycles stays in db_estado=5 with no repeat capture.
- Timeout: no press -> with TIMEOUT_JOGADA_EN, ERRO after 10 cycles in ESPERA_JOGADA; without it, still in db_estado=4 after 1000 cycles.
- Training mode and reset: modo_treino=1 with 5 errors -> vidas stays 2 and pontos=0 after a full game. Asserting reset mid TOCA_NOTA -> db_estado=0, nota_tocar=0, vidas=2 immediately, before the next clock edge.
